pdp_fetch_decode: RTL
=====================

PDP_FETCH_DECODE -- requirements
Module: pdp_fetch_decode

Interface
REQ-001 Parameter ADDR_WIDTH, 12, memory address width in bits.
REQ-002 Parameter DATA_WIDTH, 12, memory word width in bits.
REQ-003 Parameter START_ADDRESS, 12'o0200, program counter (PC) value after reset.
REQ-004 Port clk  in  1  free-running clock; all state changes on the rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port stall  in  1  driven by the execution unit; high while an instruction is executing.
REQ-007 Port PC_value  in  ADDR_WIDTH  next PC from the execution unit; valid when stall falls.
REQ-008 Ports ifu_rd_req out 1, ifu_rd_addr out ADDR_WIDTH, ifu_rd_data in DATA_WIDTH  memory read port; data is valid one cycle after the request.
REQ-009 Ports ifu_wr_req out 1, ifu_wr_addr out ADDR_WIDTH, ifu_wr_data out DATA_WIDTH  single-cycle memory write port.
REQ-010 Port base_addr  out  ADDR_WIDTH  address of the instruction currently issued.
REQ-011 Ports pdp_mem_opcode out pdp_mem_opcode_s, pdp_op7_opcode out pdp_op7_opcode_s  decoded instruction, one-hot flags plus mem_inst_addr.
REQ-012 Port halted  out  1  high after an HLT has been issued.

Function
REQ-013 States: IDLE, FETCH_REQ, FETCH_RCV, DECODE, IND_REQ, IND_RCV, AUTOINC, ISSUE, WAIT_EXEC, HALT.
REQ-014 IDLE always goes to FETCH_REQ, so the first ifu_rd_req is asserted in the second cycle after reset is released.
REQ-015 FETCH_REQ drives ifu_rd_req=1 and ifu_rd_addr=PC for exactly one cycle; FETCH_RCV latches ifu_rd_data into the instruction register (IR).
REQ-016 DECODE, opcodes 0-5 (IR[11:9]): effective address (EA) = IR[7] ? {PC[11:7],IR[6:0]} : {5'b0,IR[6:0]}; IR[8]=1 goes to IND_REQ, otherwise to ISSUE.
REQ-017 IND_REQ reads mem[EA] for one cycle; IND_RCV latches the pointer; EA is then set to the pointer, or to AUTOINC when enabled (REQ-031).
REQ-018 Opcode 6 (IOT) decodes as op7 NOP.
REQ-019 Opcode 7 decodes by exact octal match: 7000 NOP, 7001 IAC, 7004 RAL, 7006 RTL, 7010 RAR, 7012 RTR, 7020 CML, 7040 CMA, 7041 CIA, 7100 CLL, 7200 CLA1, 7300 CLA_CLL, 7402 HLT, 7404 OSR, 7410 SKP, 7420 SNL, 7430 SZL, 7440 SZA, 7450 SNA, 7500 SMA, 7510 SPA, 7600 CLA2; any other opcode-7 code decodes as NOP.
REQ-020 ISSUE drives exactly one flag high, mem_inst_addr=EA and base_addr=PC; outputs are held until stall is sampled high, then the state moves to WAIT_EXEC.
REQ-021 If stall is already high on entry to ISSUE, that counts as acceptance and ISSUE lasts one cycle.
REQ-022 WAIT_EXEC holds outputs while stall=1; on the first cycle with stall=0: PC<=PC_value, all flags cleared, next state FETCH_REQ (or HALT if HLT was issued).
REQ-023 HALT keeps halted=1 with no memory requests until reset.
REQ-024 All flag bits are zero outside ISSUE/WAIT_EXEC; ifu_rd_req and ifu_wr_req are never high in the same cycle.
REQ-025 Address arithmetic is modulo 2^ADDR_WIDTH: 12'o7777+1 wraps to 0.

Reset
REQ-026 While reset=1: state=IDLE, PC=START_ADDRESS, IR=0, all requests, flags, addresses and data=0, halted=0.
REQ-027 Reset asserted mid-operation clears all outputs immediately, without waiting for a clock edge.
REQ-028 Reset asserted mid-operation discards any pending indirect read or auto-increment write.

Configuration
REQ-029 Macro AUTO_INDEX_EN selects auto-index support.
REQ-030 With AUTO_INDEX_EN undefined: IND_RCV goes directly to ISSUE with EA=pointer, and ifu_wr_req is held at 0.
REQ-031 With AUTO_INDEX_EN defined: when the indirect location is 12'o0010-12'o0017, AUTOINC writes pointer+1 to that location for one cycle, sets EA=pointer+1 and then goes to ISSUE.

Verification
REQ-032 Reset release, mem[0200]=1205 -> rd_req at addr 0200 in cycle 2; TAD flag set with mem_inst_addr=0205, base_addr=0200.
REQ-033 mem[0200]=5410, mem[0010]=0377 with AUTO_INDEX_EN -> write 0400 to 0010; JMP with mem_inst_addr=0400.
REQ-034 Same program as REQ-033 without AUTO_INDEX_EN -> no write; mem_inst_addr=0377.
REQ-035 Issued instruction with stall held high for 5 cycles, PC_value=0300 -> flags stable throughout; next fetch at 0300.
REQ-036 mem[0200]=7402 -> HLT issued, halted=1, no further rd_req; mem[0201]=7777 -> NOP flag.
REQ-037 Reset asserted during IND_REQ -> rd_req drops immediately and fetch restarts at 0200.

Source files
------------

// File: rtl/pdp_fetch_decode_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pdp_fetch_decode_pkg / pdp_fetch_decode_if                               |
// | Decoded-instruction types plus the bus bundle between the PDP-8 fetch/   |
// | decode unit, its instruction memory and the execution unit.              |
// |   master : fetch/decode unit (drives memory requests and decoded flags)  |
// |   slave  : memory + execution unit (drives stall, PC_value, rd_data)     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package pdp_fetch_decode_pkg;

  // The PDP-8 instruction word format fixes the operand address at 12 bits.
  localparam int PDP_ADDR_W = 12;

  typedef struct packed {
    logic                  and_op;
    logic                  tad;
    logic                  isz;
    logic                  dca;
    logic                  jms;
    logic                  jmp;
    logic [PDP_ADDR_W-1:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic nop;
    logic iac;
    logic ral;
    logic rtl;
    logic rar;
    logic rtr;
    logic cml;
    logic cma;
    logic cia;
    logic cll;
    logic cla1;
    logic cla_cll;
    logic hlt;
    logic osr;
    logic skp;
    logic snl;
    logic szl;
    logic sza;
    logic sna;
    logic sma;
    logic spa;
    logic cla2;
  } pdp_op7_opcode_s;

endpackage

interface pdp_fetch_decode_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
);
  import pdp_fetch_decode_pkg::*;

  // execution-unit handshake
  logic                  stall;
  logic [ADDR_WIDTH-1:0] PC_value;
  // memory read port
  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic [DATA_WIDTH-1:0] ifu_rd_data;
  // memory write port
  logic                  ifu_wr_req;
  logic [ADDR_WIDTH-1:0] ifu_wr_addr;
  logic [DATA_WIDTH-1:0] ifu_wr_data;
  // decoded instruction
  logic [ADDR_WIDTH-1:0] base_addr;
  pdp_mem_opcode_s       pdp_mem_opcode;
  pdp_op7_opcode_s       pdp_op7_opcode;
  logic                  halted;

  modport master (
    input  stall, PC_value, ifu_rd_data,
    output ifu_rd_req, ifu_rd_addr, ifu_wr_req, ifu_wr_addr, ifu_wr_data,
    output base_addr, pdp_mem_opcode, pdp_op7_opcode, halted
  );

  modport slave (
    output stall, PC_value, ifu_rd_data,
    input  ifu_rd_req, ifu_rd_addr, ifu_wr_req, ifu_wr_addr, ifu_wr_data,
    input  base_addr, pdp_mem_opcode, pdp_op7_opcode, halted
  );

endinterface
`default_nettype wire

// File: rtl/pdp_fetch_decode.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pdp_fetch_decode                                                         |
// | PDP-8 instruction fetch and decode unit. Fetches the word at PC, resolves|
// | current-page / page-zero and indirect addressing, decodes it into one-hot|
// | flags and holds them until the execution unit has consumed them.         |
// | Ports:                                                                   |
// |   clk    - rising-edge clock                                             |
// |   reset  - asynchronous, active-high reset                               |
// |   bus    - pdp_fetch_decode_if.master (memory rd/wr ports, stall,        |
// |            PC_value, base_addr, decoded flags, halted)                   |
// | Build option: define AUTO_INDEX_EN for auto-index (0010-0017) support.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module pdp_fetch_decode
  import pdp_fetch_decode_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 12,
  parameter int                    DATA_WIDTH    = 12,
  parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o0200
) (
  input  wire logic             clk,
  input  wire logic             reset,
  pdp_fetch_decode_if.master    bus
);

  localparam logic [DATA_WIDTH-1:0] HLT_CODE = 12'o7402;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH_REQ = 4'd1,
    FETCH_RCV = 4'd2,
    DECODE    = 4'd3,
    IND_REQ   = 4'd4,
    IND_RCV   = 4'd5,
    AUTOINC   = 4'd6,
    ISSUE     = 4'd7,
    WAIT_EXEC = 4'd8,
    HALT      = 4'd9
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] ir;
  logic                  hlt_pending;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] base_addr;
  pdp_mem_opcode_s       mem_op;
  pdp_op7_opcode_s       op7;
  logic                  halted;

  logic [ADDR_WIDTH-1:0] ea_dir;
  logic [ADDR_WIDTH-1:0] ptr;

  // Direct effective address: IR[7] selects the current page, else page zero.
  assign ea_dir = ir[7] ? {pc[ADDR_WIDTH-1:7], ir[6:0]}
                        : {{(ADDR_WIDTH-7){1'b0}}, ir[6:0]};
  assign ptr    = bus.ifu_rd_data[ADDR_WIDTH-1:0];

  function automatic pdp_mem_opcode_s dec_mem(input logic [2:0] op,
                                              input logic [ADDR_WIDTH-1:0] addr);
    pdp_mem_opcode_s m;
    m = '0;
    case (op)
      3'd0:    m.and_op = 1'b1;
      3'd1:    m.tad    = 1'b1;
      3'd2:    m.isz    = 1'b1;
      3'd3:    m.dca    = 1'b1;
      3'd4:    m.jms    = 1'b1;
      default: m.jmp    = 1'b1;
    endcase
    m.mem_inst_addr = addr;
    return m;
  endfunction

  // Opcodes 6 (IOT) and 7 share this path; anything without an exact match,
  // including every IOT, decodes as NOP.
  function automatic pdp_op7_opcode_s dec_op7(input logic [DATA_WIDTH-1:0] w);
    pdp_op7_opcode_s o;
    o = '0;
    case (w)
      12'o7001: o.iac     = 1'b1;
      12'o7004: o.ral     = 1'b1;
      12'o7006: o.rtl     = 1'b1;
      12'o7010: o.rar     = 1'b1;
      12'o7012: o.rtr     = 1'b1;
      12'o7020: o.cml     = 1'b1;
      12'o7040: o.cma     = 1'b1;
      12'o7041: o.cia     = 1'b1;
      12'o7100: o.cll     = 1'b1;
      12'o7200: o.cla1    = 1'b1;
      12'o7300: o.cla_cll = 1'b1;
      12'o7402: o.hlt     = 1'b1;
      12'o7404: o.osr     = 1'b1;
      12'o7410: o.skp     = 1'b1;
      12'o7420: o.snl     = 1'b1;
      12'o7430: o.szl     = 1'b1;
      12'o7440: o.sza     = 1'b1;
      12'o7450: o.sna     = 1'b1;
      12'o7500: o.sma     = 1'b1;
      12'o7510: o.spa     = 1'b1;
      12'o7600: o.cla2    = 1'b1;
      default:  o.nop     = 1'b1;
    endcase
    return o;
  endfunction

`ifdef AUTO_INDEX_EN
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  auto_loc;

  // Indirect through 0010-0017: the pointer address still sits on rd_addr.
  assign auto_loc = (rd_addr[ADDR_WIDTH-1:3] == (ADDR_WIDTH-3)'(1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= START_ADDRESS;
      ir          <= '0;
      hlt_pending <= 1'b0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      base_addr   <= '0;
      mem_op      <= '0;
      op7         <= '0;
      halted      <= 1'b0;
`ifdef AUTO_INDEX_EN
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rd_req  <= 1'b1;
          rd_addr <= pc;
          state   <= FETCH_REQ;
        end
        FETCH_REQ: begin
          rd_req <= 1'b0;
          state  <= FETCH_RCV;
        end
        FETCH_RCV: begin
          ir    <= bus.ifu_rd_data;
          state <= DECODE;
        end
        DECODE: begin
          base_addr   <= pc;
          hlt_pending <= (ir == HLT_CODE);
          if (ir[11:9] < 3'd6) begin
            if (ir[8]) begin
              rd_req  <= 1'b1;
              rd_addr <= ea_dir;
              state   <= IND_REQ;
            end else begin
              mem_op <= dec_mem(ir[11:9], ea_dir);
              state  <= ISSUE;
            end
          end else begin
            op7   <= dec_op7(ir);
            state <= ISSUE;
          end
        end
        IND_REQ: begin
          rd_req <= 1'b0;
          state  <= IND_RCV;
        end
        IND_RCV: begin
`ifdef AUTO_INDEX_EN
          if (auto_loc) begin
            wr_req  <= 1'b1;
            wr_addr <= rd_addr;
            wr_data <= bus.ifu_rd_data + DATA_WIDTH'(1);
            state   <= AUTOINC;
          end else
`endif
          begin
            mem_op <= dec_mem(ir[11:9], ptr);
            state  <= ISSUE;
          end
        end
`ifdef AUTO_INDEX_EN
        AUTOINC: begin
          // The incremented pointer being written back is the effective address.
          wr_req <= 1'b0;
          mem_op <= dec_mem(ir[11:9], wr_data[ADDR_WIDTH-1:0]);
          state  <= ISSUE;
        end
`endif
        ISSUE: begin
          if (bus.stall) begin
            state <= WAIT_EXEC;
          end
        end
        WAIT_EXEC: begin
          if (!bus.stall) begin
            pc     <= bus.PC_value;
            mem_op <= '0;
            op7    <= '0;
            if (hlt_pending) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              rd_req  <= 1'b1;
              rd_addr <= bus.PC_value;
              state   <= FETCH_REQ;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ifu_rd_req     = rd_req;
  assign bus.ifu_rd_addr    = rd_addr;
  assign bus.base_addr      = base_addr;
  assign bus.pdp_mem_opcode = mem_op;
  assign bus.pdp_op7_opcode = op7;
  assign bus.halted         = halted;

`ifdef AUTO_INDEX_EN
  assign bus.ifu_wr_req  = wr_req;
  assign bus.ifu_wr_addr = wr_addr;
  assign bus.ifu_wr_data = wr_data;
`else
  assign bus.ifu_wr_req  = 1'b0;
  assign bus.ifu_wr_addr = '0;
  assign bus.ifu_wr_data = '0;
`endif

endmodule
`default_nettype wire
